// File: rtl/yutorina_bus_slave_response_mux_if.sv
// Bus bundle between a master and the slave response multiplexer.
// Latency: n/a (wires only).
// Backpressure: none; the slave side signals completion through slave_ready_.
//
// Ports (all active-low strobes end in '_'):
//   master_request_, slave_chip_select_, slave_read_data, slave_ready_ : toward the mux
//   master_read_data, master_ready_, master_error, master_slave_index  : from the mux
// Modports: slave  = view of the multiplexer itself
//           master = view of the agent driving requests and slave responses

`ifndef YUTORINA_WORD_DATA_WIDTH
`define YUTORINA_WORD_DATA_WIDTH 32
`endif
`ifndef YUTORINA_ENABLE_
`define YUTORINA_ENABLE_ 1'b0
`endif
`ifndef YUTORINA_DISABLE_
`define YUTORINA_DISABLE_ 1'b1
`endif

interface yutorina_bus_slave_response_mux_if #(
  parameter int SLAVE_COUNT = 8,
  parameter int DATA_WIDTH  = `YUTORINA_WORD_DATA_WIDTH
);
  localparam int IDX_W = $clog2(SLAVE_COUNT);

  logic                              master_request_;
  logic [SLAVE_COUNT-1:0]            slave_chip_select_;
  logic [SLAVE_COUNT*DATA_WIDTH-1:0] slave_read_data;
  logic [SLAVE_COUNT-1:0]            slave_ready_;
  logic [DATA_WIDTH-1:0]             master_read_data;
  logic                              master_ready_;
  logic                              master_error;
  logic [IDX_W-1:0]                  master_slave_index;

  modport slave (
    input  master_request_, slave_chip_select_, slave_read_data, slave_ready_,
    output master_read_data, master_ready_, master_error, master_slave_index
  );

  modport master (
    output master_request_, slave_chip_select_, slave_read_data, slave_ready_,
    input  master_read_data, master_ready_, master_error, master_slave_index
  );
endinterface

// File: rtl/yutorina_bus_slave_response_mux.sv
// Selects one slave's read response and returns it to the bus master.
// Latency: ready_ seen in WAIT cycle t -> master_ready_ in cycle t+1 (all outputs registered).
// Backpressure: master holds master_request_ until master_ready_; dropping it in WAIT aborts.
//
// Ports: clk, reset (synchronous, active high), bus (yutorina_bus_slave_response_mux_if.slave).
// Optional feature: define YUTORINA_BUS_TIMEOUT_EN to end a WAIT that lasts TIMEOUT_CYCLES
// cycles without ready with an error response.

`ifndef YUTORINA_WORD_DATA_WIDTH
`define YUTORINA_WORD_DATA_WIDTH 32
`endif
`ifndef YUTORINA_ENABLE_
`define YUTORINA_ENABLE_ 1'b0
`endif
`ifndef YUTORINA_DISABLE_
`define YUTORINA_DISABLE_ 1'b1
`endif

module yutorina_bus_slave_response_mux #(
  parameter int SLAVE_COUNT    = 8,
  parameter int DATA_WIDTH     = `YUTORINA_WORD_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                clk,
  input  logic                                reset,
  yutorina_bus_slave_response_mux_if.slave    bus
);
  localparam int IDX_W = $clog2(SLAVE_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] read_data_q;
  logic                  ready_q;
  logic                  error_q;
  logic [IDX_W-1:0]      index_q;

`ifdef YUTORINA_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]      wait_cnt;
`endif

  // Lowest-numbered asserted chip select wins; scanning downward leaves the lowest.
  logic             cs_any;
  logic [IDX_W-1:0] cs_low;
  always_comb begin
    cs_any = 1'b0;
    cs_low = '0;
    for (int i = SLAVE_COUNT - 1; i >= 0; i--) begin
      if (bus.slave_chip_select_[i] == `YUTORINA_ENABLE_) begin
        cs_any = 1'b1;
        cs_low = IDX_W'(i);
      end
    end
  end

  // Only the latched slave is observed while waiting.
  logic                  sel_ready;
  logic [DATA_WIDTH-1:0] sel_data;
  assign sel_ready = (bus.slave_ready_[index_q] == `YUTORINA_ENABLE_);
  assign sel_data  = bus.slave_read_data[index_q*DATA_WIDTH +: DATA_WIDTH];

  wire request = (bus.master_request_ == `YUTORINA_ENABLE_);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ready_q     <= `YUTORINA_DISABLE_;
      read_data_q <= '0;
      error_q     <= 1'b0;
      index_q     <= '0;
`ifdef YUTORINA_BUS_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      // Strobe is a single-cycle pulse; only a transition into RESPOND re-asserts it.
      ready_q <= `YUTORINA_DISABLE_;
      case (state)
        ST_IDLE: begin
          if (request) begin
            if (cs_any) begin
              index_q  <= cs_low;
              state    <= ST_WAIT;
`ifdef YUTORINA_BUS_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end else begin
              // Decode error: nobody selected.
              read_data_q <= '0;
              error_q     <= 1'b1;
              ready_q     <= `YUTORINA_ENABLE_;
              state       <= ST_RESPOND;
            end
          end
        end
        ST_WAIT: begin
          // Abort beats a same-cycle ready: the master no longer wants the data.
          if (!request) begin
            state <= ST_IDLE;
          end else if (sel_ready) begin
            read_data_q <= sel_data;
            error_q     <= 1'b0;
            ready_q     <= `YUTORINA_ENABLE_;
            state       <= ST_RESPOND;
          end
`ifdef YUTORINA_BUS_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
            read_data_q <= '0;
            error_q     <= 1'b1;
            ready_q     <= `YUTORINA_ENABLE_;
            state       <= ST_RESPOND;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        ST_RESPOND: begin
          // A held request is picked up again from IDLE on the next cycle.
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.master_read_data   = read_data_q;
  assign bus.master_ready_      = ready_q;
  assign bus.master_error       = error_q;
  assign bus.master_slave_index = index_q;

endmodule

// File: tb/tb_yutorina_bus_slave_response_mux.sv
// Testbench for yutorina_bus_slave_response_mux (SLAVE_COUNT=8, DATA_WIDTH=32, TIMEOUT_CYCLES=4).
// Latency: n/a.
// Backpressure: n/a.

module tb_yutorina_bus_slave_response_mux;
  localparam int SC  = 8;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  yutorina_bus_slave_response_mux_if #(.SLAVE_COUNT(SC), .DATA_WIDTH(DW)) bus ();

  yutorina_bus_slave_response_mux #(
    .SLAVE_COUNT(SC), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic e_rdy, input logic e_err,
                           input logic [31:0] e_data, input logic [2:0] e_idx);
    check({nm, "_ready"}, {31'd0, bus.master_ready_}, {31'd0, e_rdy});
    check({nm, "_error"}, {31'd0, bus.master_error}, {31'd0, e_err});
    check({nm, "_data"}, bus.master_read_data, e_data);
    check({nm, "_index"}, {29'd0, bus.master_slave_index}, {29'd0, e_idx});
  endtask

  typedef struct {
    logic        rst;
    logic        req;
    logic [7:0]  cs;
    logic [7:0]  rdy;
    int          rd_slave;
    logic [31:0] rd_word;
    logic        e_rdy;
    logic        e_err;
    logic [31:0] e_data;
    logic [2:0]  e_idx;
  } vec_t;

  vec_t tbl[31];

  task automatic drive(input logic rst, input logic req, input logic [7:0] cs,
                       input logic [7:0] rdy, input int rd_slave, input logic [31:0] rd_word);
    reset                 = rst;
    bus.master_request_   = req;
    bus.slave_chip_select_ = cs;
    bus.slave_ready_      = rdy;
    for (int i = 0; i < SC; i++)
      bus.slave_read_data[i*DW +: DW] = (i == rd_slave) ? rd_word : (32'hBAD0_0000 | i);
  endtask

  // Reference model: tracks an outstanding access by its slave number and elapsed wait.
  logic        m_busy, m_resp, m_rdy, m_err;
  logic [31:0] m_data;
  int          m_idx, m_waited;

  task automatic model_step(input logic rst, input logic req, input logic [7:0] cs,
                            input logic [7:0] rdy, input logic [SC*DW-1:0] rd);
    m_rdy = 1'b1;
    if (rst) begin
      m_busy = 0; m_resp = 0; m_data = 0; m_err = 0; m_idx = 0; m_waited = 0;
    end else if (m_resp) begin
      m_resp = 0;
    end else if (!m_busy) begin
      if (!req) begin
        if (cs != 8'hFF) begin
          for (int i = SC - 1; i >= 0; i--) if (!cs[i]) m_idx = i;
          m_busy = 1; m_waited = 0;
        end else begin
          m_data = 0; m_err = 1; m_rdy = 0; m_resp = 1;
        end
      end
    end else begin
      if (req) begin
        m_busy = 0;
      end else if (!rdy[m_idx]) begin
        m_data = rd[m_idx*DW +: DW]; m_err = 0; m_rdy = 0; m_resp = 1; m_busy = 0;
      end else begin
`ifdef YUTORINA_BUS_TIMEOUT_EN
        if (m_waited == TMO) begin
          m_data = 0; m_err = 1; m_rdy = 0; m_resp = 1; m_busy = 0;
        end else begin
          m_waited++;
        end
`endif
      end
    end
  endtask

  initial begin
    drive(1'b1, 1'b1, 8'hFF, 8'hFF, 0, 32'h0);

    //          rst req cs     rdy    sl word          rdy err data          idx
    tbl[0]  = '{1, 1, 8'hFF, 8'hFF, 0, 32'h0,        1, 0, 32'h0,        3'd0};
    tbl[1]  = '{0, 1, 8'h00, 8'hFF, 0, 32'h0,        1, 0, 32'h0,        3'd0};
    tbl[2]  = '{0, 0, 8'hF7, 8'hFF, 0, 32'h0,        1, 0, 32'h0,        3'd3};
    tbl[3]  = '{0, 0, 8'hF7, 8'hFF, 0, 32'h0,        1, 0, 32'h0,        3'd3};
    tbl[4]  = '{0, 0, 8'hF7, 8'hF7, 3, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 3'd3};
    tbl[5]  = '{0, 1, 8'hFF, 8'hFF, 0, 32'h0,        1, 0, 32'hDEADBEEF, 3'd3};
    tbl[6]  = '{0, 0, 8'hDD, 8'hFF, 0, 32'h0,        1, 0, 32'hDEADBEEF, 3'd1};
    tbl[7]  = '{0, 0, 8'hDD, 8'hDF, 5, 32'h55,       1, 0, 32'hDEADBEEF, 3'd1};
    tbl[8]  = '{0, 0, 8'hDD, 8'hFD, 1, 32'h11,       0, 0, 32'h11,       3'd1};
    tbl[9]  = '{0, 1, 8'hFF, 8'hFF, 0, 32'h0,        1, 0, 32'h11,       3'd1};
    tbl[10] = '{0, 0, 8'hFF, 8'hFF, 0, 32'h0,        0, 1, 32'h0,        3'd1};
    tbl[11] = '{0, 1, 8'hFF, 8'hFF, 0, 32'h0,        1, 1, 32'h0,        3'd1};
    tbl[12] = '{0, 0, 8'hFB, 8'hFF, 0, 32'h0,        1, 1, 32'h0,        3'd2};
    tbl[13] = '{0, 0, 8'hFB, 8'hFF, 0, 32'h0,        1, 1, 32'h0,        3'd2};
    tbl[14] = '{0, 1, 8'hFB, 8'hFF, 0, 32'h0,        1, 1, 32'h0,        3'd2};
    tbl[15] = '{0, 1, 8'hFF, 8'hFB, 2, 32'h22,       1, 1, 32'h0,        3'd2};
    tbl[16] = '{0, 0, 8'hFB, 8'hFF, 0, 32'h0,        1, 1, 32'h0,        3'd2};
    tbl[17] = '{0, 1, 8'hFB, 8'hFB, 2, 32'h33,       1, 1, 32'h0,        3'd2};
    tbl[18] = '{0, 1, 8'hFF, 8'hFB, 2, 32'h33,       1, 1, 32'h0,        3'd2};
    tbl[19] = '{0, 0, 8'hEF, 8'hFF, 0, 32'h0,        1, 1, 32'h0,        3'd4};
    tbl[20] = '{0, 0, 8'hEF, 8'hEF, 4, 32'h44,       0, 0, 32'h44,       3'd4};
    tbl[21] = '{1, 0, 8'hEF, 8'hEF, 4, 32'h44,       1, 0, 32'h0,        3'd0};
    tbl[22] = '{0, 0, 8'h7F, 8'hFF, 0, 32'h0,        1, 0, 32'h0,        3'd7};
    tbl[23] = '{0, 0, 8'h7F, 8'h7F, 7, 32'h77,       0, 0, 32'h77,       3'd7};
    tbl[24] = '{0, 1, 8'hFF, 8'hFF, 0, 32'h0,        1, 0, 32'h77,       3'd7};
    tbl[25] = '{0, 0, 8'hFE, 8'hFF, 0, 32'h0,        1, 0, 32'h77,       3'd0};
    tbl[26] = '{0, 0, 8'hFE, 8'hFE, 0, 32'hA0,       0, 0, 32'hA0,       3'd0};
    tbl[27] = '{0, 0, 8'hFD, 8'hFF, 0, 32'h0,        1, 0, 32'hA0,       3'd0};
    tbl[28] = '{0, 0, 8'hFD, 8'hFF, 0, 32'h0,        1, 0, 32'hA0,       3'd1};
    tbl[29] = '{0, 0, 8'hFD, 8'hFD, 1, 32'hB1,       0, 0, 32'hB1,       3'd1};
    tbl[30] = '{0, 1, 8'hFF, 8'hFF, 0, 32'h0,        1, 0, 32'hB1,       3'd1};

    for (int r = 0; r < 31; r++) begin
      drive(tbl[r].rst, tbl[r].req, tbl[r].cs, tbl[r].rdy, tbl[r].rd_slave, tbl[r].rd_word);
      @(posedge clk); #1;
      check_all($sformatf("row%0d", r), tbl[r].e_rdy, tbl[r].e_err, tbl[r].e_data, tbl[r].e_idx);
    end

    // Slave 6 never answers.
`ifdef YUTORINA_BUS_TIMEOUT_EN
    for (int k = 0; k <= TMO + 1; k++) begin
      drive(1'b0, 1'b0, 8'hBF, 8'hFF, 0, 32'h0);
      @(posedge clk); #1;
      if (k == TMO + 1)
        check_all($sformatf("tmo%0d", k), 1'b0, 1'b1, 32'h0, 3'd6);
      else
        check({$sformatf("tmo%0d", k), "_ready"}, {31'd0, bus.master_ready_}, 32'd1);
    end
`else
    for (int k = 0; k < 100; k++) begin
      drive(1'b0, 1'b0, 8'hBF, 8'hFF, 0, 32'h0);
      @(posedge clk); #1;
      check({$sformatf("notmo%0d", k), "_ready"}, {31'd0, bus.master_ready_}, 32'd1);
    end
    check("notmo_error", {31'd0, bus.master_error}, 32'd0);
`endif
    drive(1'b0, 1'b1, 8'hFF, 8'hFF, 0, 32'h0);
    @(posedge clk); #1;

    // Randomized run against the model; the first cycle resets both.
    for (int c = 0; c < 2000; c++) begin
      logic rst, req;
      logic [7:0] cs, rdy;
      rst = (c == 0) || ($urandom_range(0, 99) < 2);
      req = ($urandom_range(0, 99) < 20);
      cs  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      for (int i = 0; i < SC; i++) rdy[i] = ($urandom_range(0, 99) >= 30);
      reset                  = rst;
      bus.master_request_    = req;
      bus.slave_chip_select_ = cs;
      bus.slave_ready_       = rdy;
      for (int i = 0; i < SC; i++) bus.slave_read_data[i*DW +: DW] = $urandom;
      model_step(rst, req, cs, rdy, bus.slave_read_data);
      @(posedge clk); #1;
      check_all($sformatf("rnd%0d", c), m_rdy, m_err, m_data, 3'(m_idx));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/yutorina_bus_slave_response_mux.md
YUTORINA_BUS_SLAVE_RESPONSE_MUX -- requirements
Module: yutorina_bus_slave_response_mux

Interface
REQ-001 Parameter SLAVE_COUNT, default 8: number of slave response channels, legal range 2..16.
REQ-002 Parameter DATA_WIDTH, default `YUTORINA_WORD_DATA_WIDTH: read data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 256: WAIT cycles before timeout, legal range 1..65535.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 master_request_  in  1  master access strobe, active low (`YUTORINA_ENABLE_).
REQ-007 slave_chip_select_  in  SLAVE_COUNT  per-slave chip select, active low; bit i = slave i.
REQ-008 slave_read_data  in  SLAVE_COUNT*DATA_WIDTH  packed read data; slave i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 slave_ready_  in  SLAVE_COUNT  per-slave ready, active low.
REQ-010 master_read_data  out  DATA_WIDTH  registered response data.
REQ-011 master_ready_  out  1  registered response strobe, active low, one cycle per access.
REQ-012 master_error  out  1  high with master_ready_ when the response is a decode error or a timeout.
REQ-013 master_slave_index  out  $clog2(SLAVE_COUNT)  index of the slave latched for the current access.

Function
REQ-014 FSM states: IDLE, WAIT, RESPOND.
REQ-015 IDLE with master_request_ asserted and any chip select asserted: latch the lowest asserted index into master_slave_index; go to WAIT.
REQ-016 IDLE with master_request_ asserted and no chip select asserted: decode error; go to RESPOND with data 0 and error 1.
REQ-017 IDLE with master_request_ deasserted: ignore chip selects; stay in IDLE.
REQ-018 WAIT with latched slave's ready_ asserted: register its read data; go to RESPOND with error 0.
REQ-019 WAIT: only the latched slave's ready_ and data are observed; other slaves' ready_ are ignored.
REQ-020 WAIT with master_request_ deasserted (abort): go to IDLE; no response is produced. Abort takes priority over ready in the same cycle.
REQ-021 Latency: ready_ sampled asserted in WAIT cycle t gives master_ready_ asserted in cycle t+1. Minimum access = request cycle + 1 WAIT cycle + 1 RESPOND cycle.
REQ-022 RESPOND: master_ready_ asserted for exactly one cycle, then IDLE unconditionally. A request held through RESPOND starts a new access in the following IDLE cycle.
REQ-023 master_read_data and master_error hold their values outside RESPOND until the next response is registered.
REQ-024 master_ready_ is `YUTORINA_DISABLE_ in all states other than RESPOND.

Reset
REQ-025 reset is sampled on clk. When asserted: state IDLE, master_ready_ `YUTORINA_DISABLE_, master_read_data 0, master_error 0, master_slave_index 0, timeout counter 0.
REQ-026 reset during WAIT or RESPOND discards the access; no master_ready_ is emitted afterwards.
REQ-027 reset takes priority over every other event in the same cycle.

Configuration
REQ-028 When macro YUTORINA_BUS_TIMEOUT_EN is defined, a counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT and increments each WAIT cycle without ready.
REQ-029 With YUTORINA_BUS_TIMEOUT_EN defined, when the counter equals TIMEOUT_CYCLES in WAIT with no ready: go to RESPOND with data 0 and error 1. Ready in that same cycle wins (normal response).
REQ-030 Without YUTORINA_BUS_TIMEOUT_EN: no counter; WAIT lasts until ready or abort; master_error is raised only by decode errors.

Verification
REQ-031 SLAVE_COUNT=8. Request with CS3 asserted; slave3 ready_ asserted 2 cycles later with data 0xDEADBEEF -> one master_ready_ pulse, data 0xDEADBEEF, error 0, index 3.
REQ-032 CS1 and CS5 asserted together; slave5 ready_ asserted first, then slave1 ready_ with 0x11 -> slave5 ignored; response data 0x11, index 1.
REQ-033 Request with no CS -> master_ready_ asserted 1 cycle later, data 0, error 1.
REQ-034 YUTORINA_BUS_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, slave never ready -> error response in cycle 6 after request. Without the macro -> no response within 100 cycles.
REQ-035 Request deasserted in WAIT cycle 2 -> IDLE, no master_ready_. Same-cycle abort and ready -> no response.
REQ-036 reset asserted in the RESPOND cycle -> master_ready_ deasserted next cycle; all outputs 0 or disabled; the next access works normally.
